// File: rtl/lmdpl_nor_seq_ctrl_if.sv
// Operand and result valid/ready channels of the masked NOR sequencer.
// master drives operands and accepts results; slave is the controller.
interface lmdpl_nor_seq_ctrl_if;
  logic op_valid;
  logic op_ready;
  logic op_a;
  logic op_b;
  logic res_valid;
  logic res_ready;
  logic res;

  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res
  );

  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res
  );
endinterface

// File: rtl/lmdpl_nor_seq_ctrl.sv
// Sequencer for a masked dual-rail NOR gate: latches operands, draws masks
// from an LFSR, runs precharge/evaluate and returns the sampled result.
module lmdpl_nor_seq_ctrl #(
  parameter int unsigned PRE_CYCLES  = 2,
  parameter int unsigned EVAL_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  lmdpl_nor_seq_ctrl_if.slave        bus,
  output logic                       in0,
  output logic                       in1,
  output logic                       m_in0,
  output logic                       m_in1,
  output logic                       m_out,
  output logic                       precharge,
  input  logic                       gate_out,
  output logic                       busy
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [7:0] PRE_LD  = 8'(PRE_CYCLES - 1);
  localparam logic [7:0] EVAL_LD = 8'(EVAL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic [15:0] r_lfsr, w_lfsr;
  logic        r_in0, w_in0;
  logic        r_in1, w_in1;
  logic        r_m_in0, w_m_in0;
  logic        r_m_in1, w_m_in1;
  logic        r_m_out, w_m_out;
  logic        r_pre, w_pre;
  logic        r_rdy, w_rdy;
  logic        r_vld, w_vld;
  logic        r_res, w_res;
  logic        r_busy, w_busy;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_lfsr  <= SEED;
      r_in0   <= 1'b0;
      r_in1   <= 1'b0;
      r_m_in0 <= 1'b0;
      r_m_in1 <= 1'b0;
      r_m_out <= 1'b0;
      r_pre   <= 1'b1;
      r_rdy   <= 1'b1;
      r_vld   <= 1'b0;
      r_res   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_lfsr  <= w_lfsr;
      r_in0   <= w_in0;
      r_in1   <= w_in1;
      r_m_in0 <= w_m_in0;
      r_m_in1 <= w_m_in1;
      r_m_out <= w_m_out;
      r_pre   <= w_pre;
      r_rdy   <= w_rdy;
      r_vld   <= w_vld;
      r_res   <= w_res;
      r_busy  <= w_busy;
    end
  end

  // Next values of every output register, so all outputs stay glitch-free.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_lfsr  = r_lfsr;
    w_in0   = r_in0;
    w_in1   = r_in1;
    w_m_in0 = r_m_in0;
    w_m_in1 = r_m_in1;
    w_m_out = r_m_out;
    w_pre   = r_pre;
    w_rdy   = r_rdy;
    w_vld   = r_vld;
    w_res   = r_res;
    w_busy  = r_busy;
    unique case (r_state)
      S_IDLE: begin
        if (bus.op_valid && r_rdy) begin
          w_in0   = bus.op_a;
          w_in1   = bus.op_b;
          w_rdy   = 1'b0;
          w_busy  = 1'b1;
          w_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_m_in0 = r_lfsr[0];
        w_m_in1 = r_lfsr[5];
        w_m_out = r_lfsr[11];
        w_lfsr  = {r_lfsr[14:0], w_fb};
        w_cnt   = PRE_LD;
        w_state = S_PRE;
      end
      S_PRE: begin
        if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else begin
          w_cnt   = EVAL_LD;
          w_pre   = 1'b0;
          w_state = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else begin
          w_res   = gate_out;
          w_vld   = 1'b1;
          w_pre   = 1'b1;
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_vld   = 1'b0;
          w_rdy   = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_pre   = 1'b1;
        w_rdy   = 1'b1;
        w_vld   = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign in0           = r_in0;
  assign in1           = r_in1;
  assign m_in0         = r_m_in0;
  assign m_in1         = r_m_in1;
  assign m_out         = r_m_out;
  assign precharge     = r_pre;
  assign busy          = r_busy;
  assign bus.op_ready  = r_rdy;
  assign bus.res_valid = r_vld;
  assign bus.res       = r_res;

endmodule

// File: tb/tb_lmdpl_nor_seq_ctrl.sv
// Scoreboard bench for the masked NOR sequencer, default and 1/1 builds.
// Gate modelled as NOR of the inputs, forced low while precharged.
module tb_lmdpl_nor_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sel;
  logic op_valid, op_a, op_b, res_ready;

  lmdpl_nor_seq_ctrl_if bus0 ();
  lmdpl_nor_seq_ctrl_if bus1 ();

  assign bus0.op_valid  = op_valid & ~sel;
  assign bus0.res_ready = res_ready & ~sel;
  assign bus0.op_a      = op_a;
  assign bus0.op_b      = op_b;
  assign bus1.op_valid  = op_valid & sel;
  assign bus1.res_ready = res_ready & sel;
  assign bus1.op_a      = op_a;
  assign bus1.op_b      = op_b;

  logic in0_0, in1_0, mi0_0, mi1_0, mo_0, pre_0, busy_0, g_0;
  logic in0_1, in1_1, mi0_1, mi1_1, mo_1, pre_1, busy_1, g_1;

  assign g_0 = pre_0 ? 1'b0 : ~(in0_0 | in1_0);
  assign g_1 = pre_1 ? 1'b0 : ~(in0_1 | in1_1);

  lmdpl_nor_seq_ctrl u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .in0(in0_0), .in1(in1_0),
    .m_in0(mi0_0), .m_in1(mi1_0), .m_out(mo_0),
    .precharge(pre_0), .gate_out(g_0), .busy(busy_0)
  );

  lmdpl_nor_seq_ctrl #(
    .PRE_CYCLES(1), .EVAL_CYCLES(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .in0(in0_1), .in1(in1_1),
    .m_in0(mi0_1), .m_in1(mi1_1), .m_out(mo_1),
    .precharge(pre_1), .gate_out(g_1), .busy(busy_1)
  );

  wire o_rdy  = sel ? bus1.op_ready  : bus0.op_ready;
  wire o_vld  = sel ? bus1.res_valid : bus0.res_valid;
  wire o_res  = sel ? bus1.res       : bus0.res;
  wire o_pre  = sel ? pre_1  : pre_0;
  wire o_busy = sel ? busy_1 : busy_0;
  wire [1:0] o_in = sel ? {in0_1, in1_1} : {in0_0, in1_0};
  wire [2:0] o_m  = sel ? {mi0_1, mi1_1, mo_1}
                        : {mi0_0, mi1_0, mo_0};

  int total = 0;
  int bad   = 0;
  logic [15:0] mdl [2];
  logic        sb [$];
  logic [2:0]  last_m;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic run_op(input logic a, input logic b,
                        input int bp, input bit poke);
    int k, plow, lat_exp, ev_exp;
    bit ok_rdy, ok_stab, ok_bp;
    logic [2:0] em;
    logic r0, exp_r;
    lat_exp = sel ? 4 : 6;
    ev_exp  = sel ? 1 : 2;
    @(negedge clk);
    chk("idle_rdy", o_rdy, 1);
    em = {mdl[sel][0], mdl[sel][5], mdl[sel][11]};
    sb.push_back(~(a | b));
    op_a = a; op_b = b; op_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    mdl[sel] = nxt(mdl[sel]);
    k = 1; plow = 0; ok_rdy = 1; ok_stab = 1;
    while (!o_vld && k < 40) begin
      if (o_rdy) ok_rdy = 0;
      if (k >= 2 && {o_in, o_m} != {a, b, em}) ok_stab = 0;
      if (!o_pre) plow++;
      if (poke && k == 3) begin
        op_valid = 1'b1; op_a = ~a; op_b = ~b;
      end
      if (poke && k == 5) op_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    op_valid = 1'b0;
    chk("latency", k, lat_exp);
    chk("busy_rdy_low", ok_rdy, 1);
    chk("in_mask_stable", ok_stab, 1);
    chk("pre_low_cycles", plow, ev_exp);
    chk("masks", o_m, em);
    last_m = o_m;
    r0 = o_res;
    ok_bp = 1;
    repeat (bp) begin
      @(negedge clk);
      if (o_res !== r0 || !o_vld || !o_pre || o_rdy || !o_busy)
        ok_bp = 0;
    end
    if (bp > 0) chk("backpressure", ok_bp, 1);
    res_ready = 1'b1;
    @(posedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      exp_r = sb.pop_front();
      chk("res", r0, exp_r);
    end
    @(negedge clk);
    res_ready = 1'b0;
    chk("ret_rdy", o_rdy, 1);
    chk("ret_vld", o_vld, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0;
    op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
    mdl[0] = 16'hACE1; mdl[1] = 16'hACE1;
    #12;
    chk("rst_pre", o_pre, 1);
    chk("rst_rdy", o_rdy, 1);
    chk("rst_vld", o_vld, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_regs", {o_in, o_m, o_res}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 0, 1'b0);
    chk("seed_masks", last_m, 3'b111);
    run_op(1'b1, 1'b0, 10, 1'b0);
    chk("second_masks", last_m, 3'b101);
    run_op(1'b0, 1'b1, 0, 1'b1);

    // reset while evaluating: op discarded, LFSR back at seed
    @(negedge clk);
    op_a = 1'b1; op_b = 1'b1; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (o_pre && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_eval", o_pre, 0);
    rst = 1'b1;
    #1;
    chk("arst_pre", o_pre, 1);
    chk("arst_vld", o_vld, 0);
    chk("arst_busy", o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    mdl[0] = 16'hACE1; mdl[1] = 16'hACE1;
    run_op(1'b1, 1'b1, 0, 1'b0);
    chk("post_rst_masks", last_m, 3'b111);

    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      run_op(ab[1], ab[0], (i == 2) ? 3 : 0, 1'b0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lmdpl_nor_seq_ctrl.md
Name: lmdpl_nor_seq_ctrl

Overview:
- Upstream sequencer for the masked dual-rail NOR gate stage.
- Accepts plaintext operand pairs over a valid/ready handshake and draws fresh masks (m_in0, m_in1, m_out) from an internal LFSR.
- Drives the gate's precharge/evaluate phases and samples the gate's unmasked output.
- Returns the result over a second valid/ready handshake. One operation in flight at a time.

Parameters:
- PRE_CYCLES, 2, number of cycles precharge is held high before evaluate (legal 1..255).
- EVAL_CYCLES, 2, number of evaluate cycles before the gate output is sampled (legal 1..255).
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset. A value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  controller can accept an operand pair.
- op_a  in  1  plaintext operand 0.
- op_b  in  1  plaintext operand 1.
- in0  out  1  registered op_a to the gate.
- in1  out  1  registered op_b to the gate.
- m_in0  out  1  mask for in0.
- m_in1  out  1  mask for in1.
- m_out  out  1  output mask (table generation and unmasking).
- precharge  out  1  1 = gate rails forced to precharge.
- gate_out  in  1  unmasked NOR result from the gate.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res  out  1  captured NOR result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, precharge=1, op_ready=1, in0/in1/m_in0/m_in1/m_out/res=0, res_valid=0, busy=0, counter=0, lfsr=LFSR_SEED (0 is replaced by 16'hACE1).
- LFSR: 16-bit Fibonacci.
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances exactly once per accepted operation, in LOAD; it never advances otherwise.
  - Masks are sampled from the pre-advance value: m_in0=l[0], m_in1=l[5], m_out=l[11].
- FSM states: IDLE, LOAD, PRE, EVAL, DONE. All outputs are registered.
  - IDLE: op_ready=1, precharge=1. On op_valid&op_ready, latch op_a/op_b into in0/in1, then go to LOAD.
  - LOAD (1 cycle): drive masks from lfsr, advance lfsr, precharge=1, counter=PRE_CYCLES-1, then go to PRE.
  - PRE: precharge=1. While counter!=0, decrement. At 0, go to EVAL with counter=EVAL_CYCLES-1.
  - EVAL: precharge=0. While counter!=0, decrement. At 0, capture res<=gate_out, then go to DONE.
  - DONE: res_valid=1, precharge=1. On res_ready, go to IDLE with res_valid=0.
- op_ready is 0 in every state except IDLE. op_valid outside IDLE is ignored, and operands do not change.
- in0/in1/masks hold stable from LOAD until the next accepted op. This guarantees the gate inputs and masks never toggle during EVAL.
- precharge is low only in EVAL. It is 1 in the first LOAD cycle, so masks settle while the rails are precharged.
- Latency: accept edge to first res_valid cycle = 2 + PRE_CYCLES + EVAL_CYCLES cycles (6 with defaults). With res_ready held high, throughput is one op per 3 + PRE_CYCLES + EVAL_CYCLES cycles.
- res is held stable while res_valid=1 and res_ready=0 (backpressure), for any duration.
- Reset asserted mid-operation forces the reset values immediately. The in-flight op is discarded and never reported. The LFSR restarts from the seed.
- PRE_CYCLES/EVAL_CYCLES = 1 means exactly one cycle in that state. The counter is 8 bits wide.

Test Plan:
- Reset, then op_a=0, op_b=0 accepted, res_ready=1 -> masks (m_in0,m_in1,m_out)=(1,1,1) from seed ACE1; precharge low for exactly 2 cycles; res_valid in 6th cycle after accept; res=gate_out sampled in last EVAL cycle (model gate as ~(in0|in1) -> res=1).
- Second op op_a=1, op_b=0 -> lfsr=16'h59C3, masks=(1,0,1), res=0; op_ready low from accept until DONE exits.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid and res stay constant, precharge=1, op_ready=0; res_ready=1 -> IDLE next cycle, op_ready=1.
- op_valid pulsed during PRE/EVAL with different operands -> ignored; in0/in1 and masks unchanged through EVAL.
- Assert rst during EVAL -> same cycle precharge=1, res_valid=0, busy=0; next op again uses masks (1,1,1).
- PRE_CYCLES=1, EVAL_CYCLES=1 build -> accept-to-res_valid latency 4 cycles; all four (op_a,op_b) combinations return NOR correctly.
